// File: rtl/pipe_mux_tree_if.sv
// pipe_mux_tree_if: request/response bundle for pipe_mux_tree.
// Ports (master drives requests, slave returns results):
//   din[N*W], sel[SB], in_valid, en  -> request side
//   dout[W], out_valid, out_sel[SB]  <- result side
//   scan                             -> only with PIPE_MUX_AUTOSCAN_EN
interface pipe_mux_tree_if #(
  parameter int W = 8,
  parameter int N = 16
);
  localparam int SB = $clog2(N);
  logic [N*W-1:0] din;
  logic [SB-1:0]  sel;
  logic           in_valid;
  logic           en;
`ifdef PIPE_MUX_AUTOSCAN_EN
  logic           scan;
`endif
  logic [W-1:0]   dout;
  logic           out_valid;
  logic [SB-1:0]  out_sel;
`ifdef PIPE_MUX_AUTOSCAN_EN
  modport master (output din, sel, in_valid, en, scan, input dout, out_valid, out_sel);
  modport slave  (input din, sel, in_valid, en, scan, output dout, out_valid, out_sel);
`else
  modport master (output din, sel, in_valid, en, input dout, out_valid, out_sel);
  modport slave  (input din, sel, in_valid, en, output dout, out_valid, out_sel);
`endif
endinterface

// File: rtl/pipe_mux_tree.sv
// pipe_mux_tree: pipelined N-to-1 mux of W-bit words built from registered 4:1 levels.
// Ports: clk, rst_n (async active-low), bus (pipe_mux_tree_if.slave):
//   din/sel/in_valid sampled on enabled edges, en advances the whole pipe,
//   dout/out_valid/out_sel appear L = log4(N) enabled edges after sampling.
// Optional: PIPE_MUX_AUTOSCAN_EN adds bus.scan and a free-running select counter.
module pipe_mux_tree #(
  parameter int W = 8,
  parameter int N = 16
) (
  input logic            clk,
  input logic            rst_n,
  pipe_mux_tree_if.slave bus
);
  localparam int SB = $clog2(N);
  localparam int L  = SB / 2;
  logic [N*W-1:0] stg_data [L];
  logic [SB-1:0]  stg_tag  [L];
  logic           stg_vld  [L];
  logic [N*W-1:0] data_d [L];
  logic [N*W-1:0] data_q [L];
  logic [SB-1:0]  tag_d  [L];
  logic [SB-1:0]  tag_q  [L];
  logic           vld_d  [L];
  logic           vld_q  [L];
  logic [SB-1:0]  sel_in;
  logic           vld_in;
`ifdef PIPE_MUX_AUTOSCAN_EN
  logic [SB-1:0]  cnt_d;
  logic [SB-1:0]  cnt_q;
  // SB bits cover exactly N words, so natural overflow gives the N-1 -> 0 wrap.
  always_comb begin
    cnt_d  = bus.en && bus.scan ? cnt_q + 1'b1 : cnt_q;
    sel_in = bus.scan ? cnt_q : bus.sel;
    vld_in = bus.scan | bus.in_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  always_comb begin
    sel_in = bus.sel;
    vld_in = bus.in_valid;
  end
`endif
  // Level k reads the previous level's registers together with the tag of the
  // same transaction, so each level is steered by its own slot's select.
  always_comb begin
    stg_data[0] = bus.din;
    stg_tag[0]  = sel_in;
    stg_vld[0]  = vld_in;
    for (int k = 1; k < L; k++) begin
      stg_data[k] = data_q[k-1];
      stg_tag[k]  = tag_q[k-1];
      stg_vld[k]  = vld_q[k-1];
    end
    for (int k = 0; k < L; k++) begin
      data_d[k] = '0;
      for (int g = 0; g < (N >> (2*k+2)); g++)
        data_d[k][g*W +: W] = stg_data[k][(4*g + int'(stg_tag[k][2*k +: 2]))*W +: W];
      tag_d[k] = stg_tag[k];
      vld_d[k] = stg_vld[k];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
        vld_q[k]  <= 1'b0;
      end
    end else if (bus.en) begin
      data_q <= data_d;
      tag_q  <= tag_d;
      vld_q  <= vld_d;
    end
  assign bus.dout      = data_q[L-1][W-1:0];
  assign bus.out_valid = vld_q[L-1];
  assign bus.out_sel   = tag_q[L-1];
endmodule

// File: tb/tb_pipe_mux_tree.sv
// tb_pipe_mux_tree: checks three pipe_mux_tree configurations against a delay-line model.
module tb_pipe_mux_tree;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [127:0] din_a;
  logic [255:0] din_b;
  logic [31:0]  din_c;
  logic [3:0] sel_a = '0;
  logic [5:0] sel_b = '0;
  logic [1:0] sel_c = '0;
  logic iv_a = 1'b0, iv_b = 1'b0, iv_c = 1'b0;
  logic scan_a = 1'b0;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;

  pipe_mux_tree_if #(.W(8), .N(16)) ia ();
  pipe_mux_tree_if #(.W(4), .N(64)) ib ();
  pipe_mux_tree_if #(.W(8), .N(4))  ic ();
  assign ia.din = din_a;
  assign ia.sel = sel_a;
  assign ia.in_valid = iv_a;
  assign ia.en = en;
  assign ib.din = din_b;
  assign ib.sel = sel_b;
  assign ib.in_valid = iv_b;
  assign ib.en = en;
  assign ic.din = din_c;
  assign ic.sel = sel_c;
  assign ic.in_valid = iv_c;
  assign ic.en = en;
`ifdef PIPE_MUX_AUTOSCAN_EN
  assign ia.scan = scan_a;
  assign ib.scan = 1'b0;
  assign ic.scan = 1'b0;
`endif

  pipe_mux_tree #(.W(8), .N(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  pipe_mux_tree #(.W(4), .N(64)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  pipe_mux_tree #(.W(8), .N(4))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Model: each enabled edge records {valid, sel, word[sel]} per DUT; the
  // output is whatever was recorded latency-many enabled edges earlier.
  int hv [3][3];
  int hs [3][3];
  int hd [3][3];
  int scnt;
  always @(posedge clk or negedge rst_n) begin : mdl
    int s;
    int v;
    if (!rst_n) begin
      for (int d = 0; d < 3; d++)
        for (int j = 0; j < 3; j++) begin
          hv[d][j] = 0;
          hs[d][j] = 0;
          hd[d][j] = 0;
        end
      scnt = 0;
    end else if (en) begin
      for (int d = 0; d < 3; d++)
        for (int j = 2; j > 0; j--) begin
          hv[d][j] = hv[d][j-1];
          hs[d][j] = hs[d][j-1];
          hd[d][j] = hd[d][j-1];
        end
      s = int'(sel_a);
      v = int'(iv_a);
`ifdef PIPE_MUX_AUTOSCAN_EN
      if (scan_a) begin
        s = scnt;
        v = 1;
        scnt = (scnt + 1) % 16;
      end
`endif
      hv[0][0] = v;
      hs[0][0] = s;
      hd[0][0] = 'hA0 + s;
      hv[1][0] = int'(iv_b);
      hs[1][0] = int'(sel_b);
      hd[1][0] = int'(sel_b) & 15;
      hv[2][0] = int'(iv_c);
      hs[2][0] = int'(sel_c);
      hd[2][0] = 'hC0 + int'(sel_c);
    end
  end

  always @(negedge clk) begin
    chk("a_valid", int'(ia.out_valid), hv[0][1]);
    if (hv[0][1] != 0) begin
      chk("a_dout", int'(ia.dout), hd[0][1]);
      chk("a_sel", int'(ia.out_sel), hs[0][1]);
    end
    chk("b_valid", int'(ib.out_valid), hv[1][2]);
    if (hv[1][2] != 0) begin
      chk("b_dout", int'(ib.dout), hd[1][2]);
      chk("b_sel", int'(ib.out_sel), hs[1][2]);
    end
    chk("c_valid", int'(ic.out_valid), hv[2][0]);
    if (hv[2][0] != 0) begin
      chk("c_dout", int'(ic.dout), hd[2][0]);
      chk("c_sel", int'(ic.out_sel), hs[2][0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) din_a[i*8 +: 8] = 8'hA0 + 8'(i);
    for (int i = 0; i < 64; i++) din_b[i*4 +: 4] = 4'(i);
    for (int i = 0; i < 4; i++) din_c[i*8 +: 8] = 8'hC0 + 8'(i);
    step();
    step();
    chk("reset_dout", int'(ia.dout), 0);
    chk("reset_valid", int'(ia.out_valid), 0);
    chk("reset_sel", int'(ia.out_sel), 0);
    rst_n = 1'b1;
    step();
    // single request
    sel_a = 4'hB;
    iv_a = 1'b1;
    step();
    iv_a = 1'b0;
    chk("single_early", int'(ia.out_valid), 0);
    step();
    chk("single_dout", int'(ia.dout), 'hAB);
    chk("single_valid", int'(ia.out_valid), 1);
    chk("single_sel", int'(ia.out_sel), 'hB);
    step();
    chk("single_after", int'(ia.out_valid), 0);
    // sweep
    for (int i = 0; i < 16; i++) begin
      sel_a = 4'(i);
      iv_a = 1'b1;
      step();
      if (i == 1) chk("sweep_first", int'(ia.dout), 'hA0);
    end
    iv_a = 1'b0;
    chk("sweep_second_last", int'(ia.dout), 'hAE);
    step();
    chk("sweep_last", int'(ia.dout), 'hAF);
    step();
    step();
    // stall
    sel_a = 4'd3;
    iv_a = 1'b1;
    step();
    en = 1'b0;
    sel_a = 4'd7;
    step();
    en = 1'b1;
    step();
    chk("stall_o1", int'(ia.dout), 'hA3);
    sel_a = 4'd12;
    step();
    chk("stall_o2", int'(ia.dout), 'hA7);
    en = 1'b0;
    step();
    chk("stall_hold", int'(ia.dout), 'hA7);
    chk("stall_hold_v", int'(ia.out_valid), 1);
    en = 1'b1;
    iv_a = 1'b0;
    step();
    chk("stall_o3", int'(ia.dout), 'hAC);
    step();
    chk("stall_end", int'(ia.out_valid), 0);
    // reset with slots in flight
    sel_a = 4'd1;
    iv_a = 1'b1;
    step();
    sel_a = 4'd2;
    step();
    iv_a = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_dout", int'(ia.dout), 0);
    chk("arst_valid", int'(ia.out_valid), 0);
    chk("arst_sel", int'(ia.out_sel), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_stale", int'(ia.out_valid), 0);
    sel_a = 4'd5;
    iv_a = 1'b1;
    step();
    iv_a = 1'b0;
    step();
    chk("arst_new", int'(ia.dout), 'hA5);
    chk("arst_new_v", int'(ia.out_valid), 1);
    // N=64 and N=4 latency
    sel_b = 6'h2D;
    iv_b = 1'b1;
    sel_c = 2'd2;
    iv_c = 1'b1;
    step();
    iv_b = 1'b0;
    iv_c = 1'b0;
    chk("n4_dout", int'(ic.dout), 'hC2);
    chk("n4_valid", int'(ic.out_valid), 1);
    step();
    chk("n64_early", int'(ib.out_valid), 0);
    chk("n4_after", int'(ic.out_valid), 0);
    step();
    chk("n64_dout", int'(ib.dout), 'hD);
    chk("n64_valid", int'(ib.out_valid), 1);
    chk("n64_sel", int'(ib.out_sel), 'h2D);
    // mixed traffic with bubbles and stalls on all three
    for (int i = 0; i < 30; i++) begin
      sel_a = 4'((i * 7) & 15);
      iv_a = (i % 3) != 0;
      sel_b = 6'((i * 13) & 63);
      iv_b = (i % 4) != 1;
      sel_c = 2'(i & 3);
      iv_c = (i % 2) == 0;
      en = (i % 5) != 4;
      step();
    end
    iv_a = 1'b0;
    iv_b = 1'b0;
    iv_c = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
`ifdef PIPE_MUX_AUTOSCAN_EN
    scan_a = 1'b1;
    sel_a = 4'd9;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 1) chk("scan_first", int'(ia.out_sel), 0);
      if (i == 1) chk("scan_first_d", int'(ia.dout), 'hA0);
      if (i == 17) chk("scan_wrap", int'(ia.out_sel), 0);
    end
    scan_a = 1'b0;
    for (int i = 0; i < 4; i++) step();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_mux_tree.md
Name: pipe_mux_tree

Overview:
- Parametrised, pipelined N-to-1 multiplexer of W-bit words, built as a tree of registered 4:1 stages.
- Successor to the flat combinational 16:1 mux tree. Adds generic width and input count, one register per tree level, valid tagging, stall, and a select tag aligned with the output.
- Used wherever a wide source bank is funnelled to one consumer at full clock rate.

Parameters:
- W, 8, data word width in bits (1..64).
- N, 16, number of input words. Legal values: 4, 16, 64, 256 (power of 4).
- SB, derived = log2(N), select width. Localparam, not overridable.
- L, derived = SB/2, number of tree levels, which equals the pipeline latency. Localparam.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, N*W, packed input words; word i = din[i*W+W-1 : i*W].
- sel, input, SB, word index, sampled together with din.
- in_valid, input, 1, marks the current din/sel as a real request.
- en, input, 1, pipeline advance enable (1 = shift, 0 = hold).
- dout, output, W, selected word.
- out_valid, output, 1, dout carries a valid result.
- out_sel, output, SB, sel value that produced the current dout.

Behaviour:
- Level k (k = 0..L-1) is a bank of 4:1 muxes steered by sel[2k+1:2k].
- Level 0 mux g chooses among words 4g..4g+3. Level k mux g chooses among level k-1 outputs 4g..4g+3.
- Each level's mux outputs are registered.
- The unused select bits sel[SB-1:2k+2] and the full sel tag travel with each level's data through shift registers, so every level is steered by the select of its own transaction.
- Valid bit is pipelined in parallel: level 0 captures in_valid; out_valid is the last level's valid register.
- Latency: din/sel/in_valid sampled at edge t (with en=1) appear on dout/out_valid/out_sel after edge t+L-1. That is L register stages, L enabled edges.
- Throughput: one transaction per enabled cycle. Back-to-back requests with differing sel must not interfere.
- en=0: every register (data, select pipe, valid, tag) holds. din/sel/in_valid are ignored that cycle. Outputs stay stable.
- in_valid=0 with en=1: a bubble enters the pipe. Data registers may capture anything, but the valid bit for that slot is 0.
- Reset (rst_n low, any time, async): all data, select-pipe and valid registers clear to 0 immediately. dout=0, out_valid=0, out_sel=0. In-flight transactions are discarded, not replayed.
- After rst_n deasserts: first possible out_valid=1 is L enabled edges after the first in_valid=1 sample.
- No combinational path from any input to any output.
- Out-of-range sel cannot occur (SB covers exactly N). No X propagation from unused din bits.

Optional Feature:
- Macro: PIPE_MUX_AUTOSCAN_EN.
- Defined:
  - Adds input port scan (1 bit) and an internal SB-bit scan counter, reset to 0.
  - When scan=1, the counter replaces sel at level 0 and in_valid is forced to 1.
  - The counter increments by 1 on each enabled edge, wrapping N-1 -> 0. It holds when en=0.
  - When scan=0, the counter holds and sel/in_valid are used as normal.
  - Switching scan mid-stream affects only newly sampled slots; in-flight slots are unaffected.
- Undefined: no scan port, no counter. Behaviour exactly as above.

Test Plan:
- N=16, W=8, word i=0xA0+i; sel=0xB, in_valid=1 for one cycle -> after 2 edges dout=0xAB, out_valid=1, out_sel=0xB; next cycle out_valid=0.
- Same din; sel sweeps 0..15 on consecutive cycles, in_valid=1 -> dout sequence 0xA0..0xAF, one per cycle starting 2 edges after the first sample; out_valid held high for 16 cycles.
- Stream sel=3,7,12 with en=0 on the 2nd cycle -> outputs 0xA3,0xA7,0xAC in order, each output held an extra cycle during the stall; no loss or duplication of valid slots.
- rst_n pulsed low while 2 valid slots are in flight -> dout=0, out_valid=0 immediately; no stale output after release; new request sel=5 -> 0xA5 after 2 edges.
- N=64, W=4, word i=i[3:0]; sel=0x2D -> dout=0xD after exactly 3 edges; N=4 -> 1-edge latency.
- PIPE_MUX_AUTOSCAN_EN, N=16, scan=1 for 20 cycles -> out_sel 0,1,..,15,0,1,2,3 with dout=0xA0+out_sel and out_valid=1 throughout.
